// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Two registers: TXDATA (write pushes a byte) and STATUS (flags, FIFO count, overflow clear).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic        sel, wr_txdata, wr_status, clr_ovf;
  logic        full, empty, busy, push, pop, timer_done;
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic [31:0] status_word;
  logic        unused_bits;

  assign sel       = (bus_address[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = bus_write_enable && sel && !bus_address[2] && bus_byte_enable[0];
  assign wr_status = bus_write_enable && sel && bus_address[2] && bus_byte_enable[0];
  assign clr_ovf   = wr_status && bus_write_data[3];

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign busy       = (state_q != IDLE) || !empty;
  assign timer_done = (timer_q == TMR_MAX);

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push = wr_txdata && (!full || pop);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (timer_done) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_done) begin
          timer_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the next state so it changes on the state edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_ovf) overflow_d = 1'b0;
    if (wr_txdata && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= bus_write_data[7:0];
  end

  assign count_ext   = 32'(count_q);
  assign count_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {24'h0, count_sat, overflow_q, busy, empty, full};

  assign bus_read_data = (bus_read_enable && sel && bus_address[2]) ? status_word : 32'h0;
  assign uart_tx       = tx_q;
  assign tx_irq        = (state_q == IDLE) && empty;

  assign unused_bits = ^{bus_address[1:0], bus_write_data[31:8], bus_byte_enable[3:1]};

endmodule
